// File: rtl/pci_master_arb.sv
// pci_master_arb: round-robin owner selection for the shared PCI initiator port.
// It runs the REQ#/GNT# handshake, waits for an idle bus before granting, and
// keeps the latency timer that tells the owner when to end its burst.
module pci_master_arb #(
   parameter int NREQ = 2
) (
   input  logic            clk,
   input  logic            rst,        // PCI RST#, asynchronous, active-low
   input  logic [NREQ-1:0] int_req,
   input  logic [NREQ-1:0] int_done,
   output logic [NREQ-1:0] int_grant,
   input  logic [7:0]      lat_timer,
   output logic            lat_expired,
   output logic            busy,
   output logic            pci_req,
   input  logic            pci_gnt,
   input  logic            pci_frame,
   input  logic            pci_irdy
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_OWN,
      S_REL
   } state_t;

   state_t            state_q,   state_d;
   logic [PTR_W-1:0]  winner_q,  winner_d;
   logic [PTR_W-1:0]  rr_ptr_q,  rr_ptr_d;
   logic [7:0]        lat_cnt_q, lat_cnt_d;
   logic              rel_cnt_q, rel_cnt_d;
   logic [NREQ-1:0]   grant_q,   grant_d;
   logic              pci_req_q, pci_req_d;

   logic [PTR_W-1:0]  pick;
   logic              found;
   logic [NREQ-1:0]   one_hot_lsb;

   assign one_hot_lsb = {{(NREQ-1){1'b0}}, 1'b1};

   // Round-robin search: first requesting bit after the last owner, wrapping.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no latch is inferred.
      pick  = rr_ptr_q;
      found = 1'b0;
      for (int i = 1; i <= NREQ; i++) begin
         logic [PTR_W-1:0] idx;
         idx = PTR_W'((int'(rr_ptr_q) + i) % NREQ);
         if (!found && int_req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end

   // Next state, winner, latency counter and registered outputs.
   always_comb begin
      state_d   = state_q;
      winner_d  = winner_q;
      rr_ptr_d  = rr_ptr_q;
      lat_cnt_d = lat_cnt_q;
      rel_cnt_d = rel_cnt_q;

      case (state_q)
         S_IDLE: begin
            // GNT# while idle is bus parking and does not start anything.
            if (|int_req) begin
               winner_d = pick;
               state_d  = S_REQ;
            end
         end
         S_REQ: begin
            if (!int_req[winner_q]) begin
               state_d   = S_REL;
               rel_cnt_d = 1'b0;
            end else if (!pci_gnt && pci_frame && pci_irdy) begin
               state_d   = S_OWN;
               lat_cnt_d = lat_timer;
            end
         end
         S_OWN: begin
            if (lat_cnt_q != 8'd0) lat_cnt_d = lat_cnt_q - 8'd1;
            if (int_done[winner_q]) begin
               state_d   = S_REL;
               rel_cnt_d = 1'b0;
            end
         end
         S_REL: begin
            // REQ# must stay high for two clocks between transactions.
            rr_ptr_d = winner_q;
            if (rel_cnt_q) state_d = S_IDLE;
            else           rel_cnt_d = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered, so derive them from the state being entered.
      grant_d   = '0;
      pci_req_d = 1'b1;
      case (state_d)
         S_REQ: pci_req_d = 1'b0;
         S_OWN: begin
            grant_d   = one_hot_lsb << winner_d;
            pci_req_d = !int_req[winner_d];
         end
         default: ;
      endcase
   end

   // State and output registers; RST# clears everything immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         winner_q  <= '0;
         rr_ptr_q  <= PTR_W'(NREQ - 1);
         lat_cnt_q <= 8'd0;
         rel_cnt_q <= 1'b0;
         grant_q   <= '0;
         pci_req_q <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
         state_q   <= state_d;
         winner_q  <= winner_d;
         rr_ptr_q  <= rr_ptr_d;
         lat_cnt_q <= lat_cnt_d;
         rel_cnt_q <= rel_cnt_d;
         grant_q   <= grant_d;
         pci_req_q <= pci_req_d;
      end
   end

   assign int_grant   = grant_q;
   assign pci_req     = pci_req_q;
   assign busy        = (state_q != S_IDLE);
   assign lat_expired = (state_q == S_OWN) && (lat_cnt_q == 8'd0) && pci_gnt;

endmodule

// File: tb/tb_pci_master_arb.sv
// Directed bench for pci_master_arb with NREQ=2.
module tb_pci_master_arb;

   localparam int NREQ = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [NREQ-1:0] int_req = '0;
   logic [NREQ-1:0] int_done = '0;
   logic [NREQ-1:0] int_grant;
   logic [7:0]      lat_timer = 8'd8;
   logic            lat_expired;
   logic            busy;
   logic            pci_req;
   logic            pci_gnt = 1'b1;
   logic            pci_frame = 1'b1;
   logic            pci_irdy = 1'b1;

   int checks = 0;
   int errors = 0;

   pci_master_arb #(.NREQ(NREQ)) dut (
      .clk         (clk),
      .rst         (rst),
      .int_req     (int_req),
      .int_done    (int_done),
      .int_grant   (int_grant),
      .lat_timer   (lat_timer),
      .lat_expired (lat_expired),
      .busy        (busy),
      .pci_req     (pci_req),
      .pci_gnt     (pci_gnt),
      .pci_frame   (pci_frame),
      .pci_irdy    (pci_irdy)
   );

   always #5 clk = ~clk;

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick();
      checks++; if (pci_req !== 1'b1) begin errors++; $display("FAIL reset_pci_req got=%b exp=1", pci_req); end
      checks++; if (int_grant !== 2'b00) begin errors++; $display("FAIL reset_grant got=%b exp=00", int_grant); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (lat_expired !== 1'b0) begin errors++; $display("FAIL reset_lat_expired got=%b exp=0", lat_expired); end
      @(negedge clk);
      rst = 1'b1;
      tick();
   endtask

   // Test plan 1: grant at cycle 3, release cycles 7-8, idle at cycle 9.
   task automatic test_single();
      int_req = 2'b01;                    // cycle 0
      tick();                             // cycle 1
      checks++; if (pci_req !== 1'b0) begin errors++; $display("FAIL single_req_c1 got=%b exp=0", pci_req); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_c1 got=%b exp=1", busy); end
      tick();                             // cycle 2
      checks++; if (int_grant !== 2'b00) begin errors++; $display("FAIL single_grant_c2 got=%b exp=00", int_grant); end
      pci_gnt = 1'b0;
      tick();                             // cycle 3
      checks++; if (int_grant !== 2'b01) begin errors++; $display("FAIL single_grant_c3 got=%b exp=01", int_grant); end
      pci_gnt = 1'b1;
      tick();                             // cycle 4
      checks++; if (pci_req !== 1'b0) begin errors++; $display("FAIL single_own_req_c4 got=%b exp=0", pci_req); end
      tick();                             // cycle 5
      tick();                             // cycle 6
      int_done = 2'b01;
      int_req  = 2'b00;
      tick();                             // cycle 7
      int_done = 2'b00;
      checks++; if (int_grant !== 2'b00) begin errors++; $display("FAIL single_grant_c7 got=%b exp=00", int_grant); end
      checks++; if (pci_req !== 1'b1) begin errors++; $display("FAIL single_req_c7 got=%b exp=1", pci_req); end
      tick();                             // cycle 8
      checks++; if (pci_req !== 1'b1) begin errors++; $display("FAIL single_req_c8 got=%b exp=1", pci_req); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_c8 got=%b exp=1", busy); end
      pci_gnt = 1'b0;                     // parked grant while idle
      tick();                             // cycle 9
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_c9 got=%b exp=0", busy); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_parked_busy got=%b exp=0", busy); end
      pci_gnt = 1'b1;
   endtask

   task automatic test_round_robin();
      logic [NREQ-1:0] exp;
      int n;
      test_reset();
      int_req = 2'b11;
      pci_gnt = 1'b0;
      for (int k = 0; k < 4; k++) begin
         exp = (k % 2 == 0) ? 2'b01 : 2'b10;
         n = 0;
         while (int_grant === 2'b00 && n < 10) begin
            tick();
            n++;
            checks++; if (int_grant === 2'b11) begin errors++; $display("FAIL rr_multihot got=%b exp=one-hot", int_grant); end
         end
         checks++; if (int_grant !== exp) begin errors++; $display("FAIL rr_grant_%0d got=%b exp=%b", k, int_grant, exp); end
         int_done = int_grant;
         tick();
         int_done = 2'b00;
         checks++; if (int_grant !== 2'b00) begin errors++; $display("FAIL rr_release_%0d got=%b exp=00", k, int_grant); end
      end
      int_req = 2'b00;
      pci_gnt = 1'b1;
      tick();
      tick();
      tick();
   endtask

   task automatic test_bus_busy();
      int_req   = 2'b01;
      pci_gnt   = 1'b0;
      pci_frame = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (int_grant !== 2'b00) begin errors++; $display("FAIL busbusy_grant_%0d got=%b exp=00", i, int_grant); end
         checks++; if (pci_req !== 1'b0) begin errors++; $display("FAIL busbusy_req_%0d got=%b exp=0", i, pci_req); end
      end
      pci_frame = 1'b1;
      pci_irdy  = 1'b0;
      tick();
      checks++; if (int_grant !== 2'b00) begin errors++; $display("FAIL busbusy_irdy_low got=%b exp=00", int_grant); end
      pci_irdy = 1'b1;
      tick();
      checks++; if (int_grant !== 2'b01) begin errors++; $display("FAIL busbusy_grant_idle got=%b exp=01", int_grant); end
      int_done = 2'b01;
      int_req  = 2'b00;
      pci_gnt  = 1'b1;
      tick();
      int_done = 2'b00;
      tick();
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busbusy_idle got=%b exp=0", busy); end
   endtask

   task automatic test_lat_timer();
      lat_timer = 8'd4;
      int_req   = 2'b01;
      pci_gnt   = 1'b0;
      tick();
      tick();                             // OWN cycle 0
      checks++; if (int_grant !== 2'b01) begin errors++; $display("FAIL lat_own got=%b exp=01", int_grant); end
      pci_gnt = 1'b1;
      tick();                             // OWN cycle 1
      checks++; if (lat_expired !== 1'b0) begin errors++; $display("FAIL lat_c1 got=%b exp=0", lat_expired); end
      tick();
      tick();                             // OWN cycle 3
      checks++; if (lat_expired !== 1'b0) begin errors++; $display("FAIL lat_c3 got=%b exp=0", lat_expired); end
      tick();                             // OWN cycle 4
      checks++; if (lat_expired !== 1'b1) begin errors++; $display("FAIL lat_c4 got=%b exp=1", lat_expired); end
      tick();                             // OWN cycle 5
      checks++; if (lat_expired !== 1'b1) begin errors++; $display("FAIL lat_c5 got=%b exp=1", lat_expired); end
      pci_gnt = 1'b0;
      #1;
      checks++; if (lat_expired !== 1'b0) begin errors++; $display("FAIL lat_gnt_back got=%b exp=0", lat_expired); end
      pci_gnt = 1'b1;
      #1;
      checks++; if (lat_expired !== 1'b1) begin errors++; $display("FAIL lat_gnt_off got=%b exp=1", lat_expired); end
      int_done = 2'b01;
      int_req  = 2'b00;
      tick();
      int_done = 2'b00;
      tick();
      tick();

      // Zero timer: expiry as soon as GNT# goes away.
      lat_timer = 8'd0;
      int_req   = 2'b01;
      pci_gnt   = 1'b0;
      tick();
      tick();
      checks++; if (lat_expired !== 1'b0) begin errors++; $display("FAIL lat0_gnt_low got=%b exp=0", lat_expired); end
      pci_gnt = 1'b1;
      #1;
      checks++; if (lat_expired !== 1'b1) begin errors++; $display("FAIL lat0_gnt_high got=%b exp=1", lat_expired); end
      int_done = 2'b01;
      int_req  = 2'b00;
      tick();
      int_done = 2'b00;
      tick();
      tick();
      lat_timer = 8'd8;
   endtask

   task automatic test_withdraw();
      int_req = 2'b01;
      tick();
      checks++; if (pci_req !== 1'b0) begin errors++; $display("FAIL wd_req got=%b exp=0", pci_req); end
      int_req = 2'b00;
      tick();
      checks++; if (pci_req !== 1'b1) begin errors++; $display("FAIL wd_rel1_req got=%b exp=1", pci_req); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wd_rel1_busy got=%b exp=1", busy); end
      checks++; if (int_grant !== 2'b00) begin errors++; $display("FAIL wd_rel1_grant got=%b exp=00", int_grant); end
      tick();
      checks++; if (pci_req !== 1'b1) begin errors++; $display("FAIL wd_rel2_req got=%b exp=1", pci_req); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wd_rel2_busy got=%b exp=1", busy); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wd_idle got=%b exp=0", busy); end
      checks++; if (int_grant !== 2'b00) begin errors++; $display("FAIL wd_idle_grant got=%b exp=00", int_grant); end
   endtask

   task automatic test_async_reset();
      int n;
      int_req = 2'b10;
      pci_gnt = 1'b0;
      tick();
      tick();
      checks++; if (int_grant !== 2'b10) begin errors++; $display("FAIL ar_own got=%b exp=10", int_grant); end
      #2;
      rst = 1'b0;
      #1;
      checks++; if (int_grant !== 2'b00) begin errors++; $display("FAIL ar_grant got=%b exp=00", int_grant); end
      checks++; if (pci_req !== 1'b1) begin errors++; $display("FAIL ar_req got=%b exp=1", pci_req); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_busy got=%b exp=0", busy); end
      int_req = 2'b11;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      n = 0;
      while (int_grant === 2'b00 && n < 10) begin
         tick();
         n++;
      end
      checks++; if (int_grant !== 2'b01) begin errors++; $display("FAIL ar_first_winner got=%b exp=01", int_grant); end
      int_req = 2'b00;
      pci_gnt = 1'b1;
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_bus_busy();
      test_lat_timer();
      test_withdraw();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/pci_master_arb.md
Name: pci_master_arb

Overview:
- Bus-master arbiter for the edu PCI core: shares the device's single PCI initiator port (REQ#/GNT#) between NREQ internal requesters, e.g. DMA engine and MSI writer.
- Sequences the external REQ#/GNT# handshake and waits for bus idle before handing ownership to one requester, chosen round-robin.
- Runs the PCI latency timer so the owner knows when it must terminate its burst.

Parameters:
- NREQ, 2, number of internal requesters (2..8).

Ports:
- clk  input  1  PCI clock.
- rst  input  1  asynchronous active-low reset (PCI RST#).
- int_req  input  NREQ  per-requester request; level, held until done.
- int_done  input  NREQ  per-requester one-cycle pulse: transaction finished, bus released.
- int_grant  output  NREQ  one-hot ownership; registered.
- lat_timer  input  8  latency timer value from config space (offset 0Dh).
- lat_expired  output  1  owner must end its transaction at the next data phase.
- busy  output  1  arbiter not in IDLE.
- pci_req  output  1  REQ#, active-low; registered.
- pci_gnt  input  1  GNT#, active-low.
- pci_frame  input  1  FRAME#, active-low; sampled for bus idle.
- pci_irdy  input  1  IRDY#, active-low; sampled for bus idle.

Behaviour:
- Reset (rst=0, asynchronous):
  - pci_req=1, int_grant=0, busy=0, lat_expired=0, state=IDLE.
  - rr_ptr=NREQ-1, so requester 0 wins first.
  - Applies immediately, including mid-transaction.
- States: IDLE, REQ, OWN, REL. All transitions occur on the rising edge of clk.
- IDLE:
  - If any int_req=1, latch winner = first set bit searching from rr_ptr+1 upward, modulo NREQ.
  - Go to REQ; pci_req=0 from the next cycle, i.e. 1 cycle latency.
  - pci_gnt=0 in IDLE (bus parking) is ignored.
- REQ:
  - pci_req held 0.
  - If int_req[winner]=0 (withdrawn): go to REL; no grant issued.
  - Else, if pci_gnt=0 and pci_frame=1 and pci_irdy=1 in the same sample: go to OWN. int_grant[winner]=1 from the next cycle; load lat_cnt=lat_timer.
  - Else stay. GNT# without an idle bus does not grant; GNT# may toggle freely.
- OWN:
  - int_grant held.
  - pci_req=0 while int_req[winner]=1, otherwise 1.
  - lat_cnt decrements by 1 each cycle and saturates at 0.
  - lat_expired is combinational: 1 when state=OWN and lat_cnt=0 and pci_gnt=1.
  - lat_timer=0 gives lat_expired as soon as GNT# is removed.
  - int_done[winner]=1: go to REL.
- REL:
  - int_grant=0, pci_req=1.
  - Held exactly 2 cycles: PCI requires REQ# deasserted for at least 2 clocks between transactions.
  - rr_ptr=winner.
  - Then go to IDLE.
- int_done on non-winner bits, or in any state other than OWN, is ignored.
- int_req changes in OWN/REL do not change the winner until the next IDLE decision.
- int_grant is never multi-hot; it is 0 outside OWN.
- busy = (state != IDLE).
- Fairness: with all requesters asserting continuously, grants rotate 0,1,...,NREQ-1,0.
- Minimum turnaround: IDLE, then REQ with GNT# already low, gives int_grant 2 cycles after int_req rises.

Test Plan:
1. Single request:
   - Stimulus: NREQ=2; int_req=01 at cycle 0; pci_gnt=0 with frame=irdy=1 at cycle 2.
   - Response: pci_req=0 at cycle 1; int_grant=01 at cycle 3. After int_done=01 at cycle 6, int_grant=00 and pci_req=1 for cycles 7-8; busy=0 at cycle 9.
2. Round-robin:
   - Stimulus: int_req=11 held after reset; GNT# held low, bus idle; int_done pulsed for each owner.
   - Response: grant sequence 01, 10, 01, 10; no cycle with int_grant=11.
3. Bus busy:
   - Stimulus: GNT# low while pci_frame=0 for 5 cycles.
   - Response: int_grant stays 00 and pci_req stays 0; grant asserts 1 cycle after frame and irdy both sample 1.
4. Latency timer:
   - Stimulus: lat_timer=4; enter OWN; GNT# deasserted on OWN cycle 1.
   - Response: lat_expired=1 from OWN cycle 4 onward; lat_expired=0 if GNT# is re-asserted.
5. Withdraw:
   - Stimulus: int_req=01 enters REQ; int_req dropped before GNT#.
   - Response: pci_req=1 for 2 cycles, then IDLE; int_grant never asserted.
6. Asynchronous reset:
   - Stimulus: rst=0 mid-clock while in OWN.
   - Response: int_grant=00, pci_req=1, busy=0 before the next clock edge; after release, requester 0 wins first.
